// File: rtl/dumb_pkg.sv
// Shared definitions for the dCPU data memory with program loader.
// State encoding, error flag bit positions and the idle bus word.
package dumb_pkg;

    typedef enum logic [1:0] {
        DMEM_LOAD,
        DMEM_RELEASE,
        DMEM_RUN,
        DMEM_FAULT
    } dmem_state_e;

    localparam int unsigned DMEM_ERR_CONFLICT = 0;
    localparam int unsigned DMEM_ERR_RANGE    = 1;

    // Also driven by the behavioural memory model when the bus is idle.
    localparam logic [15:0] DMEM_IDLE_WORD = 16'hAAAA;

endpackage

// File: rtl/dmem_ram_byte.sv
// Byte-wide RAM of 2**ADDR_W entries: one 16-bit write port with separate
// low/high byte addresses and a shared enable, plus two asynchronous read ports.
module dmem_ram_byte #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_lo_i,
    input  logic [ADDR_W-1:0] waddr_hi_i,
    input  logic [15:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [7:0]        rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [7:0]        rdata_b_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0] mem_q [DEPTH];

    // No reset: contents survive rst so only the loaded prefix is rewritten.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_lo_i] <= wdata_i[7:0];
            mem_q[waddr_hi_i] <= wdata_i[15:8];
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/dmem_loader.sv
// dCPU byte-addressed data RAM with a valid/ready program loader in front.
// Optional: define DMEM_WRITE_PROTECT_EN to block CPU writes into the loaded image.
module dmem_loader
    import dumb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [15:0] IDLE_WORD = DMEM_IDLE_WORD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    input  logic [7:0]      ld_data,
    input  logic            ld_last,
    output logic            ld_ready,
    output logic            cpu_rst,
    input  logic            R,
    input  logic            W,
    input  logic [15:0]     addr,
    input  logic [15:0]     data_in,
    output logic [15:0]     mem_out,
    output logic [ADDR_W:0] load_count,
    output logic            running,
    output logic [1:0]      err
);

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    dmem_state_e       state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        err_q, err_d;

    logic [ADDR_W-1:0] a_lo, a_hi;
    logic              oor, rd_req, wr_req, conflict, prot, xfer;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_wa_lo, ram_wa_hi;
    logic [15:0]       ram_wdata;
    logic [7:0]        rd_lo, rd_hi;

    assign a_lo     = addr[ADDR_W-1:0];
    assign a_hi     = a_lo + ADDR_W'(1);
    assign oor      = (addr >> ADDR_W) != 16'd0;
    assign rd_req   = (state_q == DMEM_RUN) && !R && W;
    assign wr_req   = (state_q == DMEM_RUN) && R && !W;
    assign conflict = (state_q == DMEM_RUN) && !R && !W;
    assign xfer     = ld_valid && ld_ready;

`ifdef DMEM_WRITE_PROTECT_EN
    assign prot = ({1'b0, a_lo} < count_q) || ({1'b0, a_hi} < count_q);
`else
    assign prot = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DMEM_LOAD;
            count_q <= '0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_wa_lo = count_q[ADDR_W-1:0];
        ram_wa_hi = count_q[ADDR_W-1:0];
        ram_wdata = {ld_data, ld_data};

        unique case (state_q)
            DMEM_LOAD: begin
                if (xfer) begin
                    ram_we  = 1'b1;
                    count_d = count_q + (ADDR_W + 1)'(1);
                    if (ld_last || (count_d == FULL_COUNT)) begin
                        state_d = DMEM_RELEASE;
                    end
                end
            end
            DMEM_RELEASE: state_d = DMEM_RUN;
            DMEM_RUN: begin
                if (conflict) begin
                    err_d[DMEM_ERR_CONFLICT] = 1'b1;
                    state_d                  = DMEM_FAULT;
                end else if (oor && (rd_req || wr_req)) begin
                    err_d[DMEM_ERR_RANGE] = 1'b1;
                end else if (wr_req && prot) begin
                    err_d[DMEM_ERR_RANGE] = 1'b1;
                end else if (wr_req) begin
                    ram_we    = 1'b1;
                    ram_wa_lo = a_lo;
                    ram_wa_hi = a_hi;
                    ram_wdata = data_in;
                end
            end
            DMEM_FAULT: state_d = DMEM_FAULT;
            default:    state_d = DMEM_FAULT;
        endcase
    end

    dmem_ram_byte #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk_i      (clk),
        .we_i       (ram_we),
        .waddr_lo_i (ram_wa_lo),
        .waddr_hi_i (ram_wa_hi),
        .wdata_i    (ram_wdata),
        .raddr_a_i  (a_lo),
        .rdata_a_o  (rd_lo),
        .raddr_b_i  (a_hi),
        .rdata_b_o  (rd_hi)
    );

    // The count register caps ready itself so a full image can never take one more byte.
    assign ld_ready   = (state_q == DMEM_LOAD) && !count_q[ADDR_W];
    assign cpu_rst    = (state_q != DMEM_RUN);
    assign running    = (state_q == DMEM_RUN);
    assign load_count = count_q;
    assign err        = err_q;
    assign mem_out    = (rd_req && !oor) ? {rd_hi, rd_lo} : IDLE_WORD;

endmodule

// File: tb/tb_dmem_loader.sv
// Self-checking bench for dmem_loader against a byte-array reference model.
module tb_dmem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        cpu_rst;
    logic        R = 1'b1;
    logic        W = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] mem_out;
    logic [8:0]  load_count;
    logic        running;
    logic [1:0]  err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem_m [256];
    logic [7:0] img [256];
    int         cnt_m;
    logic [1:0] err_m;

    always #5 clk = ~clk;

    dmem_loader #(
        .ADDR_W    (8),
        .IDLE_WORD (16'hAAAA)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .cpu_rst    (cpu_rst),
        .R          (R),
        .W          (W),
        .addr       (addr),
        .data_in    (data_in),
        .mem_out    (mem_out),
        .load_count (load_count),
        .running    (running),
        .err        (err)
    );

    function automatic logic [15:0] model_read(input logic [15:0] a);
        int lo;
        int hi;
        if ((a >> 8) != 0) return 16'hAAAA;
        lo = int'(a) % 256;
        hi = (lo + 1) % 256;
        return {mem_m[hi], mem_m[lo]};
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [15:0] d);
        int lo;
        int hi;
        if ((a >> 8) != 0) begin
            err_m[1] = 1'b1;
            return;
        end
        lo = int'(a) % 256;
        hi = (lo + 1) % 256;
`ifdef DMEM_WRITE_PROTECT_EN
        if (lo < cnt_m || hi < cnt_m) begin
            err_m[1] = 1'b1;
            return;
        end
`endif
        mem_m[lo] = d[7:0];
        mem_m[hi] = d[15:8];
    endfunction

    task automatic do_reset();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        R        = 1'b1;
        W        = 1'b1;
        rst      = 1'b0;
        #7;
        rst      = 1'b1;
        cnt_m    = 0;
        err_m    = 2'b00;
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = img[i];
            ld_last  = use_last && (i == n - 1);
            @(posedge clk);
            #1;
            mem_m[cnt_m] = img[i];
            cnt_m++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] q);
        addr = a;
        R    = 1'b0;
        W    = 1'b1;
        #1;
        q = mem_out;
        @(posedge clk);
        #1;
        R = 1'b1;
        if ((a >> 8) != 0) err_m[1] = 1'b1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        addr    = a;
        data_in = d;
        R       = 1'b1;
        W       = 1'b0;
        @(posedge clk);
        #1;
        W = 1'b1;
        model_write(a, d);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 6;
        if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
        if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_rst got %b want 1", cpu_rst); end
        if (load_count !== 9'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", load_count); end
        if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running got %b want 0", running); end
        if (err !== 2'b00) begin n_bad++; $display("FAIL reset_err got %b want 00", err); end
        if (mem_out !== 16'hAAAA) begin n_bad++; $display("FAIL reset_mem_out got %h want aaaa", mem_out); end
    endtask

    task automatic test_full_load();
        logic [15:0] q;
        logic [15:0] a;
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1'b1;
            ld_data  = img[i];
            ld_last  = 1'b0;
            if (i == 255) begin
                n_cmp++;
                if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_255 got %b want 1", ld_ready); end
            end
            @(posedge clk);
            #1;
            mem_m[cnt_m] = img[i];
            cnt_m++;
        end
        n_cmp += 3;
        if (load_count !== 9'd256) begin n_bad++; $display("FAIL full_count got %0d want 256", load_count); end
        if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_drop got %b want 0", ld_ready); end
        if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL full_release_cpu_rst got %b want 1", cpu_rst); end
        // A 257th byte, even flagged last, must not be taken.
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        ld_data  = 8'h5A;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        n_cmp += 3;
        if (load_count !== 9'd256) begin n_bad++; $display("FAIL full_257_count got %0d want 256", load_count); end
        if (running !== 1'b1) begin n_bad++; $display("FAIL full_running got %b want 1", running); end
        if (cpu_rst !== 1'b0) begin n_bad++; $display("FAIL full_cpu_rst got %b want 0", cpu_rst); end
        cpu_read(16'h0000, q);
        n_cmp++;
        if (q !== model_read(16'h0000)) begin n_bad++; $display("FAIL full_read_0 got %h want %h", q, model_read(16'h0000)); end
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom_range(0, 255));
            cpu_read(a, q);
            n_cmp++;
            if (q !== model_read(a)) begin n_bad++; $display("FAIL full_read addr %h got %h want %h", a, q, model_read(a)); end
        end
    endtask

    task automatic test_small_load();
        logic [15:0] q;
        rst = 1'b0;
        #2;
        n_cmp += 3;
        if (load_count !== 9'd0) begin n_bad++; $display("FAIL midrun_rst_count got %0d want 0", load_count); end
        if (running !== 1'b0) begin n_bad++; $display("FAIL midrun_rst_running got %b want 0", running); end
        if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL midrun_rst_ready got %b want 1", ld_ready); end
        rst   = 1'b1;
        cnt_m = 0;
        err_m = 2'b00;
        @(posedge clk);
        #1;
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        load_image(4, 1'b1);
        n_cmp += 4;
        if (load_count !== 9'd4) begin n_bad++; $display("FAIL small_count got %0d want 4", load_count); end
        if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL small_release_ready got %b want 0", ld_ready); end
        if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL small_release_cpu_rst got %b want 1", cpu_rst); end
        if (running !== 1'b0) begin n_bad++; $display("FAIL small_release_running got %b want 0", running); end
        @(posedge clk);
        #1;
        n_cmp += 2;
        if (cpu_rst !== 1'b0) begin n_bad++; $display("FAIL small_run_cpu_rst got %b want 0", cpu_rst); end
        if (running !== 1'b1) begin n_bad++; $display("FAIL small_run_running got %b want 1", running); end
        cpu_read(16'h0002, q);
        n_cmp++;
        if (q !== 16'h4433) begin n_bad++; $display("FAIL small_read_2 got %h want 4433", q); end
        cpu_read(16'h0010, q);
        n_cmp++;
        if (q !== model_read(16'h0010)) begin n_bad++; $display("FAIL small_keep_old got %h want %h", q, model_read(16'h0010)); end
    endtask

    task automatic test_wrap_write();
        logic [15:0] q;
        cpu_write(16'h00FF, 16'hBEEF);
        cpu_read(16'h00FF, q);
        n_cmp++;
        if (q !== model_read(16'h00FF)) begin n_bad++; $display("FAIL wrap_read_ff got %h want %h", q, model_read(16'h00FF)); end
        cpu_read(16'h0000, q);
        n_cmp++;
        if (q !== model_read(16'h0000)) begin n_bad++; $display("FAIL wrap_read_0 got %h want %h", q, model_read(16'h0000)); end
    endtask

    task automatic test_protect();
        logic [15:0] q;
        cpu_write(16'h0003, 16'h1357);
        cpu_read(16'h0003, q);
        n_cmp += 2;
        if (q !== model_read(16'h0003)) begin n_bad++; $display("FAIL prot_read_3 got %h want %h", q, model_read(16'h0003)); end
        if (err !== err_m) begin n_bad++; $display("FAIL prot_err_3 got %b want %b", err, err_m); end
`ifdef DMEM_WRITE_PROTECT_EN
        n_cmp++;
        if (q !== 16'h3344 && q !== {mem_m[4], 8'h44}) begin n_bad++; $display("FAIL prot_dropped got %h want low byte 44", q); end
`else
        n_cmp++;
        if (q !== 16'h1357) begin n_bad++; $display("FAIL noprot_write_3 got %h want 1357", q); end
`endif
        cpu_write(16'h0004, 16'h2468);
        cpu_read(16'h0004, q);
        n_cmp++;
        if (q !== 16'h2468) begin n_bad++; $display("FAIL prot_write_4 got %h want 2468", q); end
    endtask

    task automatic test_random_rw();
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] q;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) begin
                d = 16'($urandom);
                cpu_write(a, d);
            end else begin
                cpu_read(a, q);
                n_cmp++;
                if (q !== model_read(a)) begin n_bad++; $display("FAIL rand_read addr %h got %h want %h", a, q, model_read(a)); end
            end
        end
        n_cmp++;
        if (err !== err_m) begin n_bad++; $display("FAIL rand_err got %b want %b", err, err_m); end
    endtask

    task automatic test_range();
        logic [15:0] q;
        cpu_read(16'h0100, q);
        n_cmp += 2;
        if (q !== 16'hAAAA) begin n_bad++; $display("FAIL range_read got %h want aaaa", q); end
        if (err[1] !== 1'b1) begin n_bad++; $display("FAIL range_err1 got %b want 1", err[1]); end
        cpu_write(16'h1234, 16'hDEAD);
        cpu_read(16'h0034, q);
        n_cmp += 2;
        if (q !== model_read(16'h0034)) begin n_bad++; $display("FAIL range_write_dropped got %h want %h", q, model_read(16'h0034)); end
        if (err[0] !== 1'b0) begin n_bad++; $display("FAIL range_err0 got %b want 0", err[0]); end
    endtask

    task automatic test_conflict();
        logic [15:0] q;
        logic [1:0]  want;
        want    = err_m | 2'b01;
        addr    = 16'h0080;
        data_in = 16'hFFFF;
        R       = 1'b0;
        W       = 1'b0;
        @(posedge clk);
        #1;
        n_cmp += 5;
        if (err !== want) begin n_bad++; $display("FAIL conflict_err got %b want %b", err, want); end
        if (running !== 1'b0) begin n_bad++; $display("FAIL fault_running got %b want 0", running); end
        if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL fault_cpu_rst got %b want 1", cpu_rst); end
        if (mem_out !== 16'hAAAA) begin n_bad++; $display("FAIL fault_mem_out got %h want aaaa", mem_out); end
        if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL fault_ready got %b want 0", ld_ready); end
        R       = 1'b1;
        addr    = 16'h0081;
        data_in = 16'h1111;
        @(posedge clk);
        #1;
        W = 1'b1;
        @(posedge clk);
        #1;
        n_cmp += 2;
        if (err !== want) begin n_bad++; $display("FAIL fault_err_hold got %b want %b", err, want); end
        if (running !== 1'b0) begin n_bad++; $display("FAIL fault_stays got %b want 0", running); end
        rst = 1'b0;
        #2;
        n_cmp++;
        if (err !== 2'b00) begin n_bad++; $display("FAIL fault_rst_err got %b want 00", err); end
        rst   = 1'b1;
        cnt_m = 0;
        err_m = 2'b00;
        @(posedge clk);
        #1;
        img[0] = 8'h01;
        img[1] = 8'h02;
        load_image(2, 1'b1);
        @(posedge clk);
        #1;
        cpu_read(16'h0080, q);
        n_cmp++;
        if (q !== model_read(16'h0080)) begin n_bad++; $display("FAIL fault_ram_kept got %h want %h", q, model_read(16'h0080)); end
        cpu_read(16'h0000, q);
        n_cmp++;
        if (q !== 16'h0201) begin n_bad++; $display("FAIL reload_read_0 got %h want 0201", q); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_small_load();
        test_wrap_write();
        test_protect();
        test_random_rw();
        test_range();
        test_conflict();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
